rv32_wb_arbiter: RTL and testbench
==================================

# rv32_wb_arbiter

- Owns the single regfile write port (`rf_we`/`rf_waddr`/`rf_wdata`) and shares it between the in-order WB stage and the long-latency multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO and drains them in cycles the WB stage leaves the port free.
- Keeps a 32-entry pending scoreboard so decode stalls on RAW/WAW hazards against outstanding MDU destinations.
- Sits between the pipeline/MDU and the regfile write port.

## Interface
Parameters:
- `BUF_DEPTH`, 2: MDU result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive blocked-drain cycles before bubble request.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pipe_we`  in  1  WB-stage write request; cannot be stalled.
- `pipe_waddr`  in  5  WB destination.
- `pipe_wdata`  in  32  WB data.
- `mdu_valid`  in  1  MDU result valid.
- `mdu_ready`  out  1  arbiter accepts MDU result.
- `mdu_waddr`  in  5  MDU destination.
- `mdu_wdata`  in  32  MDU data.
- `sb_set`  in  1  decode issues an MDU op this cycle.
- `sb_rd`  in  5  destination of the issued MDU op.
- `dec_rs1`  in  5  decode source register 1.
- `dec_rs2`  in  5  decode source register 2.
- `dec_rd`  in  5  decode destination register.
- `hazard`  out  1  decode must stall.
- `req_bubble`  out  1  upstream must inject a WB bubble.
- `rf_we`  out  1  regfile write enable.
- `rf_waddr`  out  5  regfile write address.
- `rf_wdata`  out  32  regfile write data.
- `busy`  out  1  FIFO non-empty or any scoreboard bit set.

## Operation
- **WB always wins.** `pipe_we && pipe_waddr!=0` drives the rf port the same cycle.
- **x0 writes.** A WB write to x0 is suppressed (`rf_we=0`) and counts as a free slot.
- **Drain.** In a free slot with the FIFO non-empty, the head is written to the rf port and popped that cycle.
- **Accept.** `mdu_ready = !full`. A transfer is `mdu_valid && mdu_ready`.
  - MDU results to x0 are accepted and discarded: no enqueue, no scoreboard effect.
- **Full FIFO with simultaneous pop.**
  - `mdu_ready` stays 0 when full, even if a pop occurs the same cycle.
  - `mdu_ready` is combinational on full only.
- **Scoreboard set/clear.**
  - `sb_set && sb_rd!=0` sets `pending[sb_rd]` at the next edge.
  - A drain write of address A clears `pending[A]` at the next edge.
  - Simultaneous set and clear of the same address: set wins.
- **Hazard.** `hazard` = `pending[r]` for any nonzero r in {`dec_rs1`, `dec_rs2`, `dec_rd`}; combinational.
  - Covering `dec_rd` prevents WAW against an outstanding MDU op, so WB never writes a pending register.
- **Starvation.**
  - The counter increments each cycle the FIFO is non-empty and no drain occurs; it resets to 0 on any drain or when the FIFO is empty.
  - `req_bubble=1` while counter ≥ `STARVE_LIMIT`.
  - The counter saturates at `STARVE_LIMIT`.
- **FIFO pointers.** FIFO pointers wrap modulo `BUF_DEPTH`; the occupancy count is `$clog2(BUF_DEPTH)+1` bits.

## Timing
- **Reset values.** On reset assertion (asynchronous) and after: FIFO empty, pending=0, counter=0.
  - Resulting outputs: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0` (unless WB drives), `mdu_ready=1`, `hazard=0`, `req_bubble=0`, `busy=0`.
- **Reset mid-operation.** Buffered results and pending bits are discarded; the MDU shares `rst_n`.
- **WB latency.** The WB write reaches the rf port in the same cycle (combinational mux).
- **MDU latency.** Result accepted at edge N: earliest rf write in cycle N+1, i.e. committed at edge N+1. With bypass: see Configuration.
- **Hazard release.** `hazard` deasserts the cycle after the drain edge that clears the pending bit.
- **Bubble honoured.** Once upstream honours `req_bubble`, the FIFO head drains in that free cycle and `req_bubble` drops the next cycle.

## Configuration
- Macro: `RV32_WBARB_BYPASS_EN`.
- **Defined.** When the FIFO is empty and the WB slot is free, a valid MDU result (nonzero address) is written directly to the rf port in the same cycle and not enqueued.
  - Its scoreboard bit clears at that edge.
- **Undefined.** Every MDU result passes through the FIFO; minimum one extra cycle.

## Structure
- **Package `rv32_pkg`:**
  - `reg_addr_t` (5-bit) and `xlen_t` (32-bit) typedefs.
  - `wb_req_t` struct {`addr`, `data`}.
  - Constant `REG_ZERO`.
- **Sub-module `rv32_wb_fifo`:** parameterised synchronous FIFO of `wb_req_t`.
  - Signals: push/pop/full/empty/head.
  - Reset is asynchronous active-low.
- **Top level:** arbitration mux, scoreboard, starvation counter and hazard logic.

## Test plan
- **Reset.** Assert `rst_n=0` mid-drain with 2 FIFO entries and `pending[5]=1` → outputs immediately at reset values; after release `busy=0` and `mdu_ready=1`.
- **Priority.** `pipe_we=1`/x3/0xAAAA together with MDU x7/0x1234 accepted → x3 written that cycle; x7 written next idle cycle; `pending[7]` clears; `hazard` for `dec_rs1=7` drops the following cycle.
- **Full FIFO.** WB writes every cycle, `BUF_DEPTH=2`, three MDU results → `mdu_ready=0` after 2 accepts; `req_bubble=1` after 4 blocked cycles; one bubble drains the head.
- **Set vs clear.** `sb_set` x9 in the same cycle as a drain write of x9 → `pending[9]` remains 1.
- **x0 handling.** MDU result to x0 → accepted, `rf_we=0`, no FIFO growth; `sb_set` x0 → `hazard` never asserts.
- **Bypass.** With `RV32_WBARB_BYPASS_EN`, idle WB and MDU x4/0xBEEF → `rf_we=1` that cycle; without the macro → `rf_we=1` one cycle later.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared regfile-write types for the WB arbiter slice.
// No logic; combinational types and constants only.
package rv32_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  typedef struct packed {
    reg_addr_t addr;
    xlen_t     data;
  } wb_req_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rv32_wb_fifo.sv
// MDU result FIFO: head visible combinationally, pushed entry readable one cycle later.
// Push is ignored when full and pop when empty; owner gates push with !full.
module rv32_wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Regfile write-port arbiter: WB wins same cycle, MDU results drain from a FIFO in free slots (>=1 cycle,
// or 0 with RV32_WBARB_BYPASS_EN); mdu_ready=!full, req_bubble after STARVE_LIMIT blocked-drain cycles.
module rv32_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  input  logic        sb_set,
  input  logic [4:0]  sb_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard,
  output logic        req_bubble,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

  logic          wb_write;
  logic          drain;
  logic          bypass;
  logic          mdu_nz;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  wb_req_t       fifo_head;
  wb_req_t       mdu_req;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic [SW-1:0] starve_cnt;

  // A WB write to x0 does not occupy the port, so it is a free slot.
  assign wb_write  = pipe_we && (pipe_waddr != REG_ZERO);
  assign drain     = !wb_write && !fifo_empty;
  assign mdu_ready = !fifo_full;
  assign mdu_nz    = mdu_valid && (mdu_waddr != REG_ZERO);
  assign mdu_req   = '{addr: mdu_waddr, data: mdu_wdata};

`ifdef RV32_WBARB_BYPASS_EN
  assign bypass = !wb_write && fifo_empty && mdu_nz;
`else
  assign bypass = 1'b0;
`endif

  // x0 results are acknowledged but never stored.
  assign fifo_push = mdu_nz && !fifo_full && !bypass;

  rv32_wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (mdu_req),
    .pop   (drain),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (wb_write) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_waddr;
      rf_wdata = pipe_wdata;
    end else if (drain) begin
      rf_we    = 1'b1;
      rf_waddr = fifo_head.addr;
      rf_wdata = fifo_head.data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = mdu_waddr;
      rf_wdata = mdu_wdata;
    end
  end

  // Set is applied after the clears so a same-address set wins.
  always_comb begin
    pending_nxt = pending;
    if (drain)  pending_nxt[fifo_head.addr] = 1'b0;
    if (bypass) pending_nxt[mdu_waddr] = 1'b0;
    if (sb_set && (sb_rd != REG_ZERO)) pending_nxt[sb_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // pending[0] can never be set, so indexing with x0 reads as no hazard.
  assign hazard = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || drain) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign req_bubble = (starve_cnt >= STARVE_MAX);
  assign busy       = !fifo_empty || (pending != '0);

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Bench for rv32_wb_arbiter: directed steps plus random traffic against a queue-based reference model.
// Define RV32_WBARB_BYPASS_EN for both bench and RTL to exercise the bypass build.
module tb_rv32_wb_arbiter;
  import rv32_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef RV32_WBARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we, mdu_valid, mdu_ready, sb_set, hazard, req_bubble, rf_we, busy;
  logic [4:0]  pipe_waddr, mdu_waddr, sb_rd, dec_rs1, dec_rs2, dec_rd, rf_waddr;
  logic [31:0] pipe_wdata, mdu_wdata, rf_wdata;

  always #5 clk = ~clk;

  rv32_wb_arbiter #(
    .BUF_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_waddr  (mdu_waddr),
    .mdu_wdata  (mdu_wdata),
    .sb_set     (sb_set),
    .sb_rd      (sb_rd),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rd     (dec_rd),
    .hazard     (hazard),
    .req_bubble (req_bubble),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference state: buffered results in order, pending destinations, blocked-drain streak.
  wb_req_t     q[$];
  logic [31:0] pend;
  int          starve;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = '0;
    starve = 0;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0;
    sb_set = 0; sb_rd = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic model_check(input string tag);
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        ehz;
    ewe = 0; ea = 0; ed = 0;
    if (pipe_we && pipe_waddr != 0) begin
      ewe = 1; ea = pipe_waddr; ed = pipe_wdata;
    end else if (q.size() > 0) begin
      ewe = 1; ea = q[0].addr; ed = q[0].data;
    end else if (BYP && mdu_valid && mdu_waddr != 0) begin
      ewe = 1; ea = mdu_waddr; ed = mdu_wdata;
    end
    ehz = (dec_rs1 != 0 && pend[dec_rs1]) || (dec_rs2 != 0 && pend[dec_rs2]) ||
          (dec_rd != 0 && pend[dec_rd]);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(ea));
    chk({tag, ".rf_wdata"}, rf_wdata, ed);
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(q.size() < DEPTH));
    chk({tag, ".hazard"}, 32'(hazard), 32'(ehz));
    chk({tag, ".req_bubble"}, 32'(req_bubble), 32'(starve >= LIMIT));
    chk({tag, ".busy"}, 32'(busy), 32'(q.size() != 0 || pend != 0));
  endtask

  task automatic model_update();
    logic wb, drained, bypassed, acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wb       = pipe_we && pipe_waddr != 0;
    drained  = !wb && q.size() > 0;
    bypassed = BYP && !wb && q.size() == 0 && mdu_valid && mdu_waddr != 0;
    acc      = mdu_valid && q.size() < DEPTH;
    if (q.size() > 0 && !drained) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    else starve = 0;
    if (drained) begin
      pend[q[0].addr] = 1'b0;
      void'(q.pop_front());
    end
    if (bypassed) pend[mdu_waddr] = 1'b0;
    if (acc && mdu_waddr != 0 && !bypassed) q.push_back('{addr: mdu_waddr, data: mdu_wdata});
    if (sb_set && sb_rd != 0) pend[sb_rd] = 1'b1;
  endtask

  task automatic settle(input string tag);
    #1;
    model_check(tag);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int n);
    idle();
    repeat (n) begin
      settle("idle");
      advance();
    end
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk); #1;
    advance();
    rst_n = 1;

    // Reset values
    settle("reset");
    chk("reset.mdu_ready", 32'(mdu_ready), 32'd1);
    chk("reset.busy", 32'(busy), 32'd0);
    advance();

    // Priority: WB and MDU in the same cycle
    sb_set = 1; sb_rd = 7;
    settle("prio.issue");
    advance();
    idle();
    pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'hAAAA;
    mdu_valid = 1; mdu_waddr = 7; mdu_wdata = 32'h1234; dec_rs1 = 7;
    settle("prio.both");
    chk("prio.wb_addr", 32'(rf_waddr), 32'd3);
    chk("prio.wb_data", rf_wdata, 32'hAAAA);
    chk("prio.hazard_set", 32'(hazard), 32'd1);
    advance();
    idle(); dec_rs1 = 7;
    settle("prio.drain");
    chk("prio.drain_addr", 32'(rf_waddr), 32'd7);
    chk("prio.drain_data", rf_wdata, 32'h1234);
    chk("prio.hazard_hold", 32'(hazard), 32'd1);
    advance();
    settle("prio.release");
    chk("prio.hazard_drop", 32'(hazard), 32'd0);
    advance();

    // Set vs clear on the same address
    idle(); sb_set = 1; sb_rd = 9;
    settle("sv.issue");
    advance();
    idle(); pipe_we = 1; pipe_waddr = 1; mdu_valid = 1; mdu_waddr = 9; mdu_wdata = 32'h99;
    settle("sv.accept");
    advance();
    idle(); sb_set = 1; sb_rd = 9;
    settle("sv.drain");
    chk("sv.drain_addr", 32'(rf_waddr), 32'd9);
    advance();
    idle(); dec_rs1 = 9;
    settle("sv.after");
    chk("sv.pending_kept", 32'(hazard), 32'd1);
    advance();
    idle(); mdu_valid = 1; mdu_waddr = 9; mdu_wdata = 32'h98;
    settle("sv.retire");
    advance();
    run_idle(2);

    // Full FIFO under continuous WB writes, then one bubble
    for (int k = 0; k < 5; k++) begin
      idle();
      pipe_we = 1; pipe_waddr = 1; pipe_wdata = 32'(k);
      mdu_valid = 1; mdu_waddr = (k == 0) ? 5'd10 : (k == 1) ? 5'd11 : 5'd12;
      mdu_wdata = 32'h100 + 32'(k);
      settle("full.fill");
      if (k >= 2) chk("full.ready_low", 32'(mdu_ready), 32'd0);
      advance();
    end
    pipe_we = 0;
    settle("full.bubble");
    chk("full.req_bubble", 32'(req_bubble), 32'd1);
    chk("full.head_addr", 32'(rf_waddr), 32'd10);
    chk("full.ready_on_pop", 32'(mdu_ready), 32'd0);
    advance();
    settle("full.after");
    chk("full.bubble_drop", 32'(req_bubble), 32'd0);
    chk("full.ready_back", 32'(mdu_ready), 32'd1);
    advance();
    run_idle(3);

    // x0 handling
    idle(); mdu_valid = 1; mdu_waddr = 0; mdu_wdata = 32'h55; sb_set = 1; sb_rd = 0;
    settle("x0.accept");
    chk("x0.ready", 32'(mdu_ready), 32'd1);
    chk("x0.no_write", 32'(rf_we), 32'd0);
    advance();
    idle();
    settle("x0.after");
    chk("x0.not_busy", 32'(busy), 32'd0);
    chk("x0.no_hazard", 32'(hazard), 32'd0);
    advance();

    // Bypass versus buffered path
    idle(); sb_set = 1; sb_rd = 4;
    settle("byp.issue");
    advance();
    idle(); mdu_valid = 1; mdu_waddr = 4; mdu_wdata = 32'hBEEF;
    settle("byp.offer");
`ifdef RV32_WBARB_BYPASS_EN
    chk("byp.same_cycle", 32'(rf_we), 32'd1);
    chk("byp.same_data", rf_wdata, 32'hBEEF);
`else
    chk("byp.not_yet", 32'(rf_we), 32'd0);
`endif
    advance();
    idle();
    settle("byp.next");
`ifdef RV32_WBARB_BYPASS_EN
    chk("byp.next_idle", 32'(rf_we), 32'd0);
`else
    chk("byp.next_write", 32'(rf_we), 32'd1);
    chk("byp.next_data", rf_wdata, 32'hBEEF);
`endif
    advance();
    settle("byp.done");
    chk("byp.not_busy", 32'(busy), 32'd0);
    advance();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      pipe_we    = ($urandom_range(0, 9) < 6);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      mdu_valid  = ($urandom_range(0, 1) == 1);
      mdu_waddr  = 5'($urandom_range(0, 7));
      mdu_wdata  = $urandom;
      sb_set     = ($urandom_range(0, 9) < 3);
      sb_rd      = 5'($urandom_range(0, 7));
      dec_rs1    = 5'($urandom_range(0, 7));
      dec_rs2    = 5'($urandom_range(0, 7));
      dec_rd     = 5'($urandom_range(0, 7));
      settle("rand");
      advance();
    end
    run_idle(4);

    // Reset mid-drain with two buffered entries and pending[5]
    idle(); sb_set = 1; sb_rd = 5;
    settle("rst.issue");
    advance();
    idle(); pipe_we = 1; pipe_waddr = 2; mdu_valid = 1; mdu_waddr = 5; mdu_wdata = 32'h5;
    settle("rst.fill0");
    advance();
    mdu_waddr = 6; mdu_wdata = 32'h6;
    settle("rst.fill1");
    advance();
    idle(); dec_rs1 = 5;
    settle("rst.draining");
    #2;
    rst_n = 0;
    #1;
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst.rf_wdata", rf_wdata, 32'd0);
    chk("rst.mdu_ready", 32'(mdu_ready), 32'd1);
    chk("rst.hazard", 32'(hazard), 32'd0);
    chk("rst.req_bubble", 32'(req_bubble), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    model_reset();
    advance();
    advance();
    rst_n = 1;
    settle("rst.release");
    chk("rst.release_busy", 32'(busy), 32'd0);
    chk("rst.release_ready", 32'(mdu_ready), 32'd1);
    advance();
    run_idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
